// File: rtl/unary_shift_mac.sv
// Unary-coded multiply-accumulate. It counts the high cycles on a, b and c,
// then replays b's count once per unit of a, and then appends c's count.
// The result leaves on out as one contiguous high pulse train.
module unary_shift_mac #(
    parameter int unsigned BIN_BITS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic out
);

    localparam logic [BIN_BITS-1:0] CNT_MAX = '1;
    localparam logic [BIN_BITS-1:0] CNT_ONE = BIN_BITS'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        EMIT_MUL = 2'd2,
        EMIT_ADD = 2'd3
    } state_t;

    state_t              state;
    logic [BIN_BITS-1:0] cnt_a;
    logic [BIN_BITS-1:0] cnt_b;
    logic [BIN_BITS-1:0] cnt_c;
    logic [BIN_BITS-1:0] inner;
    logic [BIN_BITS-1:0] outer;

    // Operation sequencer: collect the operand counts, then drive the product and the addend onto out.
    // out is set on the same edge that picks the next state, so it is high in exactly the emitting cycles.
    // cnt_c also serves as the down-counter for the addend phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_c <= '0;
            inner <= '0;
            outer <= '0;
            out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out   <= 1'b0;
                    inner <= '0;
                    outer <= '0;
                    cnt_a <= BIN_BITS'(a);
                    cnt_b <= BIN_BITS'(b);
                    cnt_c <= BIN_BITS'(c);
                    if (a || b || c) begin
                        state <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (a || b || c) begin
                        if (a && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + CNT_ONE;
                        if (b && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + CNT_ONE;
                        if (c && (cnt_c != CNT_MAX)) cnt_c <= cnt_c + CNT_ONE;
                    end else if ((cnt_a != '0) && (cnt_b != '0)) begin
                        state <= EMIT_MUL;
                        inner <= cnt_b;
                        outer <= cnt_a;
                        out   <= 1'b1;
                    end else if (cnt_c != '0) begin
                        state <= EMIT_ADD;
                        out   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        cnt_a <= '0;
                        cnt_b <= '0;
                    end
                end

                EMIT_MUL: begin
                    if (inner == CNT_ONE) begin
                        if (outer == CNT_ONE) begin
                            // Product complete: continue with the addend, or finish.
                            if (cnt_c != '0) begin
                                state <= EMIT_ADD;
                                out   <= 1'b1;
                            end else begin
                                state <= IDLE;
                                out   <= 1'b0;
                                cnt_a <= '0;
                                cnt_b <= '0;
                            end
                        end else begin
                            inner <= cnt_b;
                            outer <= outer - CNT_ONE;
                            out   <= 1'b1;
                        end
                    end else begin
                        inner <= inner - CNT_ONE;
                        out   <= 1'b1;
                    end
                end

                EMIT_ADD: begin
                    if (cnt_c == CNT_ONE) begin
                        state <= IDLE;
                        out   <= 1'b0;
                        cnt_a <= '0;
                        cnt_b <= '0;
                        cnt_c <= '0;
                    end else begin
                        cnt_c <= cnt_c - CNT_ONE;
                        out   <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unary_shift_mac.sv
// Testbench for unary_shift_mac. The expected pulse count of each operation
// is computed from the operand lengths as sat(A)*sat(B)+sat(C).
module tb_unary_shift_mac;

    localparam int unsigned BIN_BITS = 4;
    localparam int          MAXV     = (1 << BIN_BITS) - 1;
    localparam int          BOUND    = 300;

    logic clk;
    logic reset_n;
    logic a;
    logic b;
    logic c;
    logic out;

    int total;
    int bad;

    typedef struct {
        int na;
        int nb;
        int nc;
        int exp;
    } vec_t;

    vec_t vecs[9];

    unary_shift_mac #(.BIN_BITS(BIN_BITS)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .a      (a),
        .b      (b),
        .c      (c),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: operand counts saturate at MAXV, and the result is a*b+c.
    function automatic int model(input int na, input int nb, input int nc);
        int sa, sb, sc;
        sa = (na > MAXV) ? MAXV : na;
        sb = (nb > MAXV) ? MAXV : nb;
        sc = (nc > MAXV) ? MAXV : nc;
        return sa * sb + sc;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive three unary operands that start together, then one all-zero cycle.
    task automatic drive_ops(input int na, input int nb, input int nc);
        int n;
        n = na;
        if (nb > n) n = nb;
        if (nc > n) n = nc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a = (i < na);
            b = (i < nb);
            c = (i < nc);
        end
        @(negedge clk);
        a = 1'b0;
        b = 1'b0;
        c = 1'b0;
    endtask

    // Count the contiguous high run starting the cycle after collection ends.
    task automatic measure(output int cnt, output bit timeout);
        cnt     = 0;
        timeout = 1'b1;
        for (int k = 0; k < BOUND; k++) begin
            @(negedge clk);
            if (out) begin
                cnt++;
            end else begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic quiet(input string name, input int cycles);
        int ones;
        ones = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (out) ones++;
        end
        check(name, ones, 0);
    endtask

    task automatic run(input string name, input int na, input int nb, input int nc, input int exp);
        int  cnt;
        bit  to;
        drive_ops(na, nb, nc);
        measure(cnt, to);
        if (to) check({name, "_timeout"}, 1, 0);
        check(name, cnt, exp);
        quiet({name, "_after"}, 10);
    endtask

    initial begin
        int  cnt;
        int  ones;
        bit  to;
        int  ra, rb, rc;

        total   = 0;
        bad     = 0;
        a       = 1'b0;
        b       = 1'b0;
        c       = 1'b0;
        reset_n = 1'b0;

        vecs[0] = '{3, 2, 6, 12};
        vecs[1] = '{4, 15, 3, 63};
        vecs[2] = '{15, 15, 0, 225};
        vecs[3] = '{3, 0, 1, 1};
        vecs[4] = '{0, 5, 3, 3};
        vecs[5] = '{10, 9, 10, 100};
        vecs[6] = '{0, 0, 4, 4};
        vecs[7] = '{17, 1, 0, 15};
        vecs[8] = '{1, 1, 1, 2};

        #1;
        check("reset_out", 32'(out), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        quiet("idle_after_reset", 5);

        // Directed table, run back-to-back.
        foreach (vecs[i]) begin
            run($sformatf("vec%0d_%0dx%0d+%0d", i, vecs[i].na, vecs[i].nb, vecs[i].nc),
                vecs[i].na, vecs[i].nb, vecs[i].nc, vecs[i].exp);
        end

        // No operands at all: out must never rise.
        quiet("all_zero_300", BOUND);

        // Pulses arriving during emission belong to no operand.
        drive_ops(3, 2, 0);
        cnt = 0;
        to  = 1'b1;
        for (int k = 0; k < BOUND; k++) begin
            @(negedge clk);
            if (!out) begin
                to = 1'b0;
                break;
            end
            cnt++;
            a = (k == 1 || k == 2);
        end
        a = 1'b0;
        if (to) check("ignore_in_emit_timeout", 1, 0);
        check("ignore_in_emit", cnt, 6);
        quiet("ignore_in_emit_after", 30);

        // Asynchronous reset in the middle of a product aborts the operation.
        drive_ops(15, 15, 0);
        ones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out) ones++;
        end
        check("pre_abort_pulses", ones, 20);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_async_out", 32'(out), 0);
        @(negedge clk);
        reset_n = 1'b1;
        quiet("abort_no_more_pulses", BOUND);
        run("after_abort_2x2+1", 2, 2, 1, 5);

        // Random operand lengths, including ragged ends and saturation.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom_range(0, MAXV + 3);
            rb = $urandom_range(0, MAXV + 3);
            rc = $urandom_range(0, MAXV + 3);
            run($sformatf("rand%0d_%0dx%0d+%0d", i, ra, rb, rc), ra, rb, rc, model(ra, rb, rc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
